buzz_seq: RTL and testbench



---
 rtl/buzz_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_buzz_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/buzz_seq.sv
`default_nettype none
// ============================================================================
// buzz_seq : ROM-driven piezo tune player with per-note tone/gap shaping.
// Revision : 1.0
// ============================================================================
module buzz_seq #(
  parameter int   DIV_SHIFT  = 0,
  parameter int   GAP_NUM    = 1,
  parameter int   GAP_DEN    = 5,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] song_sel,
  input  logic       loop,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic       done,
  output logic [5:0] note_idx
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_play = 1'b1;

  // --------------------------------------------------------------------------
  // Note tables
  // --------------------------------------------------------------------------
  function automatic logic [16:0] base_period(input logic [2:0] code);
    logic [16:0] p;
    case (code)
      3'd0:    p = 17'd98800;
      3'd1:    p = 17'd95600;
      3'd2:    p = 17'd85150;
      3'd3:    p = 17'd75850;
      3'd4:    p = 17'd71600;
      3'd5:    p = 17'd63750;
      3'd6:    p = 17'd56800;
      default: p = 17'd50600;
    endcase
    return p;
  endfunction

  function automatic logic [8:0] rep_count(input logic [2:0] code);
    logic [8:0] r;
    case (code)
      3'd0:    r = 9'd242;
      3'd1:    r = 9'd250;
      3'd2:    r = 9'd281;
      3'd3:    r = 9'd315;
      3'd4:    r = 9'd334;
      3'd5:    r = 9'd375;
      3'd6:    r = 9'd421;
      default: r = 9'd472;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] sound_thresh(input logic [2:0] code);
    logic [31:0] prod;
    prod = 32'(rep_count(code)) * 32'(GAP_DEN - GAP_NUM);
    prod = prod / 32'(GAP_DEN);
    return prod[8:0];
  endfunction

  // --------------------------------------------------------------------------
  // Song ROM: song 0 is built from three distinct 8-note bars (A B C C A B)
  // --------------------------------------------------------------------------
  function automatic logic [2:0] bar_a(input logic [2:0] pos);
    logic [2:0] c;
    case (pos)
      3'd0, 3'd1: c = 3'd1;
      3'd2, 3'd3: c = 3'd5;
      3'd4, 3'd5: c = 3'd6;
      3'd6:       c = 3'd5;
      default:    c = 3'd0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] bar_b(input logic [2:0] pos);
    logic [2:0] c;
    case (pos)
      3'd0, 3'd1: c = 3'd4;
      3'd2, 3'd3: c = 3'd3;
      3'd4, 3'd5: c = 3'd2;
      3'd6:       c = 3'd1;
      default:    c = 3'd0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] bar_c(input logic [2:0] pos);
    logic [2:0] c;
    case (pos)
      3'd0, 3'd1: c = 3'd5;
      3'd2, 3'd3: c = 3'd4;
      3'd4, 3'd5: c = 3'd3;
      3'd6:       c = 3'd2;
      default:    c = 3'd0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] song_code(input logic [1:0] song,
                                           input logic [5:0] idx);
    logic [2:0] c;
    c = 3'd0;
    case (song)
      2'd0: begin
        case (idx[5:3])
          3'd0, 3'd4: c = bar_a(idx[2:0]);
          3'd1, 3'd5: c = bar_b(idx[2:0]);
          3'd2, 3'd3: c = bar_c(idx[2:0]);
          default:    c = 3'd0;
        endcase
      end
      2'd1: c = (idx < 6'd48) ? 3'd7 : 3'd0;
      2'd2: begin
        case (idx)
          6'd0:    c = 3'd1;
          6'd1:    c = 3'd3;
          6'd2:    c = 3'd5;
          6'd3:    c = 3'd7;
          default: c = 3'd0;
        endcase
      end
      default: c = 3'd0;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] song_last(input logic [1:0] song);
    logic [5:0] l;
    case (song)
      2'd0:    l = 6'd47;
      2'd1:    l = 6'd47;
      2'd2:    l = 6'd3;
      default: l = 6'd0;
    endcase
    return l;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]  state_q,  state_d;
  logic [1:0]  song_q,   song_d;
  logic        loop_q,   loop_d;
  logic [5:0]  idx_q,    idx_d;
  logic [16:0] per_q,    per_d;
  logic [8:0]  rep_q,    rep_d;
  logic        buzzer_q, buzzer_d;
  logic        done_q,   done_d;

  logic [2:0]  w_code;
  logic [16:0] w_period;
  logic [16:0] w_half;
  logic [16:0] w_per_last;
  logic [8:0]  w_rep_last;
  logic [8:0]  w_thresh;
  logic        w_per_wrap;
  logic        w_note_end;
  logic        w_last_note;
  logic        w_gap;
  logic        w_tone_low;

  assign w_code      = song_code(song_q, idx_q);
  assign w_period    = base_period(w_code) >> DIV_SHIFT;
  assign w_half      = w_period >> 1;
  assign w_per_last  = (w_period == 17'd0) ? 17'd0 : w_period - 17'd1;
  assign w_rep_last  = rep_count(w_code);
  assign w_thresh    = sound_thresh(w_code);
  assign w_per_wrap  = (per_q >= w_per_last);
  assign w_note_end  = w_per_wrap && (rep_q >= w_rep_last);
  assign w_last_note = (idx_q >= song_last(song_q));

  // A zero numerator means no silent tail at all, so every repeat is toned.
  assign w_gap      = (GAP_NUM != 0) && (rep_q >= w_thresh);
  assign w_tone_low = (w_code != 3'd0) && !w_gap && (per_q >= w_half);

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    loop_d   = loop_q;
    idx_d    = idx_q;
    per_d    = per_q;
    rep_d    = rep_q;
    done_d   = 1'b0;
    buzzer_d = IDLE_LEVEL;
    case (state_q)
      c_st_idle: begin
        if (start && !stop) begin
          state_d = c_st_play;
          song_d  = song_sel;
          loop_d  = loop;
          idx_d   = 6'd0;
          per_d   = 17'd0;
          rep_d   = 9'd0;
        end
      end
      c_st_play: begin
        if (stop) begin
          state_d = c_st_idle;
          idx_d   = 6'd0;
          per_d   = 17'd0;
          rep_d   = 9'd0;
        end else begin
          buzzer_d = w_tone_low ? ~IDLE_LEVEL : IDLE_LEVEL;
          if (!w_per_wrap) begin
            per_d = per_q + 17'd1;
          end else begin
            per_d = 17'd0;
            if (!w_note_end) begin
              rep_d = rep_q + 9'd1;
            end else begin
              rep_d = 9'd0;
              if (!w_last_note) begin
                idx_d = idx_q + 6'd1;
              end else if (loop_q) begin
                idx_d = 6'd0;
              end else begin
                state_d = c_st_idle;
                idx_d   = 6'd0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = c_st_idle;
        idx_d   = 6'd0;
        per_d   = 17'd0;
        rep_d   = 9'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= c_st_idle;
      song_q   <= 2'd0;
      loop_q   <= 1'b0;
      idx_q    <= 6'd0;
      per_q    <= 17'd0;
      rep_q    <= 9'd0;
      buzzer_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      loop_q   <= loop_d;
      idx_q    <= idx_d;
      per_q    <= per_d;
      rep_q    <= rep_d;
      buzzer_q <= buzzer_d;
      done_q   <= done_d;
    end
  end

  assign buzzer   = buzzer_q;
  assign busy     = (state_q == c_st_play);
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_buzz_seq.sv
`default_nettype none
// ============================================================================
// tb_buzz_seq : directed self-checking bench for buzz_seq (DIV_SHIFT=13).
// Revision    : 1.0
// ============================================================================
module tb_buzz_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic       loop = 1'b0;
  logic       stop = 1'b0;
  logic       buzzer, busy, done;
  logic [5:0] note_idx;
  logic       buzzer_ng, busy_ng, done_ng;
  logic [5:0] idx_ng;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int n_done_ng = 0;

  always #5 clk = ~clk;

  buzz_seq #(.DIV_SHIFT(13), .GAP_NUM(1), .GAP_DEN(5), .IDLE_LEVEL(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .song_sel(song_sel), .loop(loop),
    .stop(stop), .buzzer(buzzer), .busy(busy), .done(done), .note_idx(note_idx)
  );

  buzz_seq #(.DIV_SHIFT(13), .GAP_NUM(0), .GAP_DEN(5), .IDLE_LEVEL(1'b1)) u_nogap (
    .clk(clk), .rst(rst), .start(start), .song_sel(song_sel), .loop(loop),
    .stop(stop), .buzzer(buzzer_ng), .busy(busy_ng), .done(done_ng), .note_idx(idx_ng)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // start is a one-cycle pulse: it is dropped after every edge
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) n_done++;
    if (done_ng) n_done_ng++;
  endtask

  task automatic run_note(input int idx, output int cnt, output int lows,
                          output int lows_ng, output logic [11:0] head);
    cnt = 0; lows = 0; lows_ng = 0; head = '0;
    while (int'(note_idx) == idx && busy && cnt < 20000) begin
      if (cnt < 12) head = {head[10:0], buzzer};
      if (!buzzer) lows++;
      if (!buzzer_ng) lows_ng++;
      tick();
      cnt++;
    end
    if (cnt >= 20000) check("note_timeout", cnt, 0);
  endtask

  initial begin
    int          cnt, lows, lows_ng;
    logic [11:0] head;
    int          s2_dur[4];
    logic [11:0] s2_head[4];
    int          s0_dur[8];
    s2_dur  = '{2761, 2844, 2632, 2838};
    s2_head = '{12'hFC0, 12'hF83, 12'hF0E, 12'hF1C};
    s0_dur  = '{2761, 2761, 2632, 2632, 2532, 2532, 2632, 2916};

    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_buzzer", int'(buzzer), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(note_idx), 0);
    rst = 1'b0;
    repeat (5) tick();
    check("no_autostart", int'(busy), 0);

    // start and stop together: stop wins
    song_sel = 2'd2; start = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("start_stop_idle", int'(busy), 0);

    // song 2 one-shot; later song_sel/loop changes must not matter
    song_sel = 2'd2; loop = 1'b0; start = 1'b1;
    tick();
    song_sel = 2'd1; loop = 1'b1;
    check("s2_busy", int'(busy), 1);
    check("s2_idx0", int'(note_idx), 0);
    check("s2_ng_busy", int'(busy_ng), 1);
    run_note(0, cnt, lows, lows_ng, head);
    check("s2_n0_dur", cnt, s2_dur[0]);
    check("s2_n0_lows", lows, 1200);
    check("s2_n0_lows_nogap", lows_ng, 1505);
    check("s2_n0_head", int'(head), int'(s2_head[0]));
    check("s2_idx1", int'(note_idx), 1);
    check("s2_ng_idx1", int'(idx_ng), 1);
    start = 1'b1;
    run_note(1, cnt, lows, lows_ng, head);
    check("s2_n1_dur", cnt, s2_dur[1]);
    check("s2_n1_lows", lows, 1260);
    check("s2_n1_lows_nogap", lows_ng, 1580);
    check("s2_n1_head", int'(head), int'(s2_head[1]));
    for (int i = 2; i < 4; i++) begin
      run_note(i, cnt, lows, lows_ng, head);
      check($sformatf("s2_n%0d_dur", i), cnt, s2_dur[i]);
      check($sformatf("s2_n%0d_head", i), int'(head), int'(s2_head[i]));
    end
    check("s2_done_pulse", int'(done), 1);
    check("s2_end_busy", int'(busy), 0);
    check("s2_end_idx", int'(note_idx), 0);
    check("s2_end_buzzer", int'(buzzer), 1);

    // restart in the done cycle, looped
    song_sel = 2'd2; loop = 1'b1; start = 1'b1;
    tick();
    check("done_one_cycle", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_idx", int'(note_idx), 0);
    check("one_done_total", n_done, 1);
    check("one_done_total_nogap", n_done_ng, 1);
    for (int i = 0; i < 4; i++) begin
      run_note(i, cnt, lows, lows_ng, head);
      check($sformatf("loop_n%0d_dur", i), cnt, s2_dur[i]);
    end
    check("loop_wrap_busy", int'(busy), 1);
    check("loop_wrap_idx", int'(note_idx), 0);
    check("loop_no_done", n_done, 1);
    repeat (7) tick();
    check("loop_tone_low", int'(buzzer), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_buzzer", int'(buzzer), 1);
    check("stop_idx", int'(note_idx), 0);
    check("stop_done", int'(done), 0);

    // asynchronous reset mid-note
    song_sel = 2'd0; loop = 1'b0; start = 1'b1;
    tick();
    repeat (7) tick();
    check("pre_rst_tone_low", int'(buzzer), 0);
    rst = 1'b1;
    #2;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_buzzer", int'(buzzer), 1);
    check("async_rst_idx", int'(note_idx), 0);
    check("async_rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", int'(busy), 0);

    // song 0 up to and through the first rest
    start = 1'b1;
    tick();
    check("s0_busy", int'(busy), 1);
    check("s0_idx0", int'(note_idx), 0);
    for (int i = 0; i < 8; i++) begin
      run_note(i, cnt, lows, lows_ng, head);
      check($sformatf("s0_n%0d_dur", i), cnt, s0_dur[i]);
    end
    check("s0_rest_lows", lows, 0);
    check("s0_idx8", int'(note_idx), 8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s0_stop_busy", int'(busy), 0);
    check("final_done_count", n_done, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
